// File: rtl/relu_pkg.sv
// ============================================================================
// Module   : relu_pkg
// Brief    : Shared types and signed select helper for the ReLU datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package relu_pkg;

  localparam int DEFAULT_BITWIDTH = 8;
  // Compares run at this width after sign extension; BITWIDTH must not exceed it.
  localparam int CMP_WIDTH = 32;

  typedef logic signed [DEFAULT_BITWIDTH-1:0] act_t;
  typedef logic signed [CMP_WIDTH-1:0]        cmp_word_t;

  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_DATA = 2'd1,
    SEL_MAX  = 2'd2
  } relu_sel_e;

  function automatic relu_sel_e relu_clamp_sel(
    input cmp_word_t x,
    input cmp_word_t thr,
    input cmp_word_t max_val,
    input logic      clip_en
  );
    relu_sel_e sel;
    if (x <= thr) begin
      sel = SEL_ZERO;
    end else if (clip_en && (x > max_val)) begin
      sel = SEL_MAX;
    end else begin
      sel = SEL_DATA;
    end
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/relu_kernel.sv
// ============================================================================
// Module   : relu_kernel
// Brief    : Combinational threshold (and optional upper clip) of one sample.
//            Upper clip enabled by defining RELU_CLIP_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module relu_kernel
  import relu_pkg::*;
#(
  parameter int                          BITWIDTH  = DEFAULT_BITWIDTH,
  parameter logic signed [BITWIDTH-1:0]  THRESHOLD = '0,
  parameter logic signed [BITWIDTH-1:0]  MAX_VAL   = BITWIDTH'(6)
) (
  input  logic signed [BITWIDTH-1:0] data_i,
  output logic signed [BITWIDTH-1:0] result_o
);

`ifdef RELU_CLIP_EN
  localparam logic CLIP_EN = 1'b1;
`else
  localparam logic CLIP_EN = 1'b0;
`endif

  cmp_word_t data_wide;
  cmp_word_t thr_wide;
  cmp_word_t max_wide;
  relu_sel_e sel;

  // Sign extension keeps the compares exact at BITWIDTH; the result is
  // always one of the input, zero or MAX_VAL, so nothing is narrowed back.
  assign data_wide = cmp_word_t'(data_i);
  assign thr_wide  = cmp_word_t'(THRESHOLD);
  assign max_wide  = cmp_word_t'(MAX_VAL);

  assign sel = relu_clamp_sel(data_wide, thr_wide, max_wide, CLIP_EN);

  always_comb begin
    result_o = data_i;
    case (sel)
      SEL_ZERO: result_o = '0;
      SEL_MAX:  result_o = MAX_VAL;
      default:  result_o = data_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/simple_relu_core.sv
// ============================================================================
// Module   : simple_relu_core
// Brief    : Registered single-lane ReLU, one-cycle latency with valid flag.
//            Upper clip (ReLU6-style) enabled by defining RELU_CLIP_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module simple_relu_core
  import relu_pkg::*;
#(
  parameter int                          BITWIDTH  = DEFAULT_BITWIDTH,
  parameter logic signed [BITWIDTH-1:0]  THRESHOLD = '0,
  parameter logic signed [BITWIDTH-1:0]  MAX_VAL   = BITWIDTH'(6)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       valid_i,
  input  logic signed [BITWIDTH-1:0] data_i,
  output logic                       valid_o,
  output logic signed [BITWIDTH-1:0] result_o
);

  logic signed [BITWIDTH-1:0] kernel_result;
  logic signed [BITWIDTH-1:0] result_q;
  logic                       valid_q;

  relu_kernel #(
    .BITWIDTH  (BITWIDTH),
    .THRESHOLD (THRESHOLD),
    .MAX_VAL   (MAX_VAL)
  ) u_kernel (
    .data_i   (data_i),
    .result_o (kernel_result)
  );

  // Result holds across idle cycles; only valid_o drops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        result_q <= kernel_result;
      end
    end
  end

  assign result_o = result_q;
  assign valid_o  = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_simple_relu_core.sv
// ============================================================================
// Module   : tb_simple_relu_core
// Brief    : Directed self-checking bench for simple_relu_core (default,
//            THRESHOLD=10 and THRESHOLD=-4 instances; RELU_CLIP_EN aware).
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_simple_relu_core;
  import relu_pkg::*;

  logic clk = 1'b0;
  logic rst_i;
  logic valid_i, valid_t, valid_n;
  act_t data_i, data_t, data_n;
  logic valid_o, valid_to, valid_no;
  act_t result_o, result_to, result_no;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  simple_relu_core u_dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .data_i(data_i),
    .valid_o(valid_o), .result_o(result_o)
  );

  simple_relu_core #(.BITWIDTH(8), .THRESHOLD(8'sd10), .MAX_VAL(8'sd20)) u_dut_thr (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_t), .data_i(data_t),
    .valid_o(valid_to), .result_o(result_to)
  );

  simple_relu_core #(.BITWIDTH(8), .THRESHOLD(-8'sd4), .MAX_VAL(8'sd6)) u_dut_neg (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_n), .data_i(data_n),
    .valid_o(valid_no), .result_o(result_no)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Default instance: threshold 0, optional clip at 6.
  function automatic act_t exp_main(input act_t x);
    act_t r;
    r = (x <= 0) ? 8'sd0 : x;
`ifdef RELU_CLIP_EN
    if (r > 8'sd6) r = 8'sd6;
`endif
    return r;
  endfunction

  act_t thr_vec [5] = '{8'sd10, 8'sd11, -8'sd5, -8'sd128, 8'sd20};
  act_t thr_exp [5] = '{8'sd0,  8'sd11, 8'sd0,  8'sd0,    8'sd20};
  act_t neg_vec [5] = '{-8'sd4, -8'sd3, -8'sd128, 8'sd5, -8'sd5};
  act_t neg_exp [5] = '{8'sd0,  -8'sd3, 8'sd0,    8'sd5, 8'sd0};
  act_t exp127;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef RELU_CLIP_EN
    exp127 = 8'sd6;
`else
    exp127 = 8'sd127;
`endif
    rst_i = 1'b1;
    valid_i = 1'b0; data_i = '0;
    valid_t = 1'b0; data_t = '0;
    valid_n = 1'b0; data_n = '0;
    repeat (2) @(negedge clk);
    check("rst_result", 32'(result_o), 0);
    check("rst_valid",  32'(valid_o), 0);

    // Asynchronous reset mid-cycle
    rst_i = 1'b0;
    data_i = 8'sd50; valid_i = 1'b1;
    @(negedge clk);
    check("pre_rst_result", 32'(result_o), 32'(exp_main(8'sd50)));
    check("pre_rst_valid",  32'(valid_o), 1);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_result", 32'(result_o), 0);
    check("async_rst_valid",  32'(valid_o), 0);
    @(negedge clk);
    check("hold_rst_result", 32'(result_o), 0);
    check("hold_rst_valid",  32'(valid_o), 0);
    rst_i = 1'b0;
    @(negedge clk);
    check("post_rst_result", 32'(result_o), 32'(exp_main(8'sd50)));
    check("post_rst_valid",  32'(valid_o), 1);

    // Full sweep -127..127 then -128
    for (int i = -127; i <= 128; i++) begin
      act_t x;
      x = 8'(i);
      data_i = x; valid_i = 1'b1;
      @(negedge clk);
      check($sformatf("sweep[%0d]", x), 32'(result_o), 32'(exp_main(x)));
      check($sformatf("sweep_valid[%0d]", x), 32'(valid_o), 1);
    end

    // Valid gating: result holds when valid_i is low
    data_i = 8'sd37; valid_i = 1'b1;
    @(negedge clk);
    check("gate_load", 32'(result_o), 32'(exp_main(8'sd37)));
    data_i = 8'sd100; valid_i = 1'b0;
    @(negedge clk);
    check("gate_valid", 32'(valid_o), 0);
    check("gate_hold",  32'(result_o), 32'(exp_main(8'sd37)));

    // Back-to-back wrap 127 / -128
    for (int k = 0; k < 8; k++) begin
      data_i = (k % 2 == 0) ? 8'sd127 : -8'sd128; valid_i = 1'b1;
      @(negedge clk);
      check($sformatf("b2b[%0d]", k), 32'(result_o), (k % 2 == 0) ? 32'(exp127) : 0);
      check($sformatf("b2b_valid[%0d]", k), 32'(valid_o), 1);
    end

`ifdef RELU_CLIP_EN
    begin
      act_t cv [5] = '{8'sd3, 8'sd6, 8'sd7, 8'sd127, -8'sd1};
      act_t ce [5] = '{8'sd3, 8'sd6, 8'sd6, 8'sd6,   8'sd0};
      for (int k = 0; k < 5; k++) begin
        data_i = cv[k]; valid_i = 1'b1;
        @(negedge clk);
        check($sformatf("clip[%0d]", cv[k]), 32'(result_o), 32'(ce[k]));
      end
    end
`endif

    // In-flight sample discarded by reset
    data_i = 8'sd77; valid_i = 1'b1;
    #2 rst_i = 1'b1;
    @(negedge clk);
    check("discard_result", 32'(result_o), 0);
    check("discard_valid",  32'(valid_o), 0);
    rst_i = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    check("discard_idle_result", 32'(result_o), 0);
    check("discard_idle_valid",  32'(valid_o), 0);
    data_i = 8'sd5; valid_i = 1'b1;
    @(negedge clk);
    check("resume_result", 32'(result_o), 32'(exp_main(8'sd5)));
    check("resume_valid",  32'(valid_o), 1);
    valid_i = 1'b0;

    // Positive and negative threshold instances
    for (int k = 0; k < 5; k++) begin
      data_t = thr_vec[k]; valid_t = 1'b1;
      data_n = neg_vec[k]; valid_n = 1'b1;
      @(negedge clk);
      check($sformatf("thr10[%0d]", thr_vec[k]), 32'(result_to), 32'(thr_exp[k]));
      check($sformatf("thrneg[%0d]", neg_vec[k]), 32'(result_no), 32'(neg_exp[k]));
      check($sformatf("thr_valid[%0d]", k), 32'(valid_to & valid_no), 1);
    end
    valid_t = 1'b0; valid_n = 1'b0;
    @(negedge clk);
    check("thr_idle_valid", 32'(valid_to | valid_no), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
